// File: rtl/int_ctrl_pkg.sv
// Shared types and MCU port map for the interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam logic [7:0] MASK_ID = 8'h60;
  localparam logic [7:0] ACK_ID  = 8'h61;
  localparam logic [7:0] PEND_ID = 8'h62;
  localparam logic [7:0] INFO_ID = 8'h63;

  // Source index width; covers up to 8 sources.
  localparam int IDX_W = 3;

endpackage

// File: rtl/int_controller_if.sv
// MCU I/O port bus: write strobe/address/data out, read data/hit back.
interface int_controller_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] RD_DATA;
  logic       RD_HIT;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input RD_DATA, RD_HIT);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output RD_DATA, RD_HIT);
endinterface

// File: rtl/int_priority_enc.sv
// Lowest-index-wins priority encoder.
module int_priority_enc
  import int_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_controller.sv
// Edge-triggered, maskable interrupt controller with MCU port interface.
// Optional acknowledge timeout under `define INT_CTRL_TIMEOUT_EN.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int PULSE_LEN   = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] SRC,
  int_controller_if.slave    bus,
  output logic               INT_OUT
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] rise, ack_clr;
  logic [IDX_W-1:0]   cur_id_q, cur_id_d, enc_idx;
  logic               enc_vld;
  logic               in_service_q, in_service_d;
  logic [3:0]         pulse_cnt_q, pulse_cnt_d;
  logic               int_out_q, int_out_d;
  logic               wr_mask, wr_ack, ack_take;
  logic               tmo_hit, timeout_flag;
  logic [7:0]         pend8;
  logic               unused_port_bits;

  assign wr_mask  = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
  assign wr_ack   = bus.IO_STRB && (bus.PORT_ID == ACK_ID);
  assign ack_take = wr_ack && (state_q == WAIT_ACK);
  assign rise     = SRC & ~src_prev_q;
  // OUT_PORT bits above NUM_SRC-1 are intentionally dropped.
  assign unused_port_bits = ^bus.OUT_PORT;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ack
    assign ack_clr[g] = ack_take && (cur_id_q == IDX_W'(g));
  end

  int_priority_enc #(.W(NUM_SRC)) u_enc (
    .vec   (pending_q & mask_q),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

`ifdef INT_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  assign tmo_hit = (state_q == WAIT_ACK) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d  = (state_q == WAIT_ACK && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
    tmo_flag_d = tmo_flag_q;
    if (tmo_hit && !ack_take)                tmo_flag_d = 1'b1;
    else if (wr_ack && state_q == IDLE)      tmo_flag_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign timeout_flag = tmo_flag_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    in_service_d = in_service_q;
    pulse_cnt_d  = pulse_cnt_q;
    int_out_d    = int_out_q;
    mask_d       = wr_mask ? bus.OUT_PORT[NUM_SRC-1:0] : mask_q;
    // A fresh edge in the ACK cycle wins over the clear.
    pending_d    = (pending_q & ~ack_clr) | rise;

    case (state_q)
      IDLE: begin
        if (enc_vld) begin
          state_d      = ASSERT;
          cur_id_d     = enc_idx;
          in_service_d = 1'b1;
          pulse_cnt_d  = 4'(PULSE_LEN);
          int_out_d    = 1'b1;
        end
      end
      ASSERT: begin
        if (pulse_cnt_q <= 4'd1) begin
          state_d     = WAIT_ACK;
          pulse_cnt_d = '0;
          int_out_d   = 1'b0;
        end else begin
          pulse_cnt_d = pulse_cnt_q - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_take || tmo_hit) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        int_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      src_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      cur_id_q     <= '0;
      in_service_q <= 1'b0;
      pulse_cnt_q  <= '0;
      int_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_prev_q   <= SRC;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      cur_id_q     <= cur_id_d;
      in_service_q <= in_service_d;
      pulse_cnt_q  <= pulse_cnt_d;
      int_out_q    <= int_out_d;
    end
  end

  assign INT_OUT = int_out_q;

  always_comb begin
    pend8              = '0;
    pend8[NUM_SRC-1:0] = pending_q;
    case (bus.PORT_ID)
      PEND_ID: bus.RD_DATA = pend8;
      INFO_ID: bus.RD_DATA = {timeout_flag, in_service_q, 3'b000, cur_id_q};
      default: bus.RD_DATA = 8'h00;
    endcase
  end

  assign bus.RD_HIT = (bus.PORT_ID == PEND_ID) || (bus.PORT_ID == INFO_ID);

endmodule

// File: tb/tb_int_controller.sv
// Directed self-checking bench for int_controller (default 4 sources, 2-cycle pulse).
module tb_int_controller;
  import int_ctrl_pkg::*;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] SRC;
  logic       INT_OUT;
  int         n_chk;
  int         n_fail;
  logic [7:0] rdv;
  int         hi;

  int_controller_if bus ();

  int_controller #(.NUM_SRC(4), .PULSE_LEN(2), .TIMEOUT_CYC(16)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .SRC     (SRC),
    .bus     (bus.slave),
    .INT_OUT (INT_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_wr(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    bus.PORT_ID = id;
    #1;
    d = bus.RD_DATA;
  endtask

  task automatic count_hi(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (INT_OUT) h++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    RESET_N = 1'b0;
    SRC = '0;
    bus.PORT_ID = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB = 1'b0;

    // Reset state
    #3;
    chk("rst_int_out", INT_OUT, 0);
    rd(PEND_ID, rdv); chk("rst_pend", rdv, 8'h00);
    rd(INFO_ID, rdv); chk("rst_info", rdv, 8'h00);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    tick();

    // Single source, 2-cycle pulse, readback
    io_wr(MASK_ID, 8'h0F);
    SRC = 4'b0100;
    count_hi(6, hi);           chk("t1_pulse_len", hi, 2);
    rd(INFO_ID, rdv);          chk("t1_info", rdv, 8'h42);
    chk("t1_hit_info", bus.RD_HIT, 1);
    rd(PEND_ID, rdv);          chk("t1_pend", rdv, 8'h04);
    rd(MASK_ID, rdv);          chk("t1_rd_other", rdv, 8'h00);
    chk("t1_hit_other", bus.RD_HIT, 0);
    io_wr(ACK_ID, 8'hAA);
    rd(PEND_ID, rdv);          chk("t1_pend_ack", rdv, 8'h00);
    rd(INFO_ID, rdv);          chk("t1_info_ack", rdv, 8'h02);
    count_hi(4, hi);           chk("t1_no_retrig", hi, 0);
    SRC = 4'b0000;
    tick();

    // Two simultaneous sources: lowest index first
    SRC = 4'b1010;
    count_hi(6, hi);           chk("t2_pulse1", hi, 2);
    rd(INFO_ID, rdv);          chk("t2_info1", rdv, 8'h41);
    rd(PEND_ID, rdv);          chk("t2_pend1", rdv, 8'h0A);
    io_wr(ACK_ID, 8'h00);
    chk("t2_gap_after_ack", INT_OUT, 0);
    tick();
    chk("t2_second_assert", INT_OUT, 1);
    count_hi(4, hi);           chk("t2_pulse2_rest", hi, 1);
    rd(INFO_ID, rdv);          chk("t2_info2", rdv, 8'h43);
    rd(PEND_ID, rdv);          chk("t2_pend2", rdv, 8'h08);
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t2_pend_clear", rdv, 8'h00);
    SRC = 4'b0000;
    tick();

    // Masked source stays pending, unmask releases it
    io_wr(MASK_ID, 8'h00);
    SRC = 4'b0001;
    count_hi(4, hi);           chk("t3_masked", hi, 0);
    rd(PEND_ID, rdv);          chk("t3_pend", rdv, 8'h01);
    rd(INFO_ID, rdv);          chk("t3_info_idle", rdv, 8'h03);
    io_wr(MASK_ID, 8'h01);
    tick();
    chk("t3_unmask_assert", INT_OUT, 1);
    count_hi(3, hi);           chk("t3_pulse_rest", hi, 1);
    rd(INFO_ID, rdv);          chk("t3_info", rdv, 8'h40);

    // Re-rise in the ACK cycle: set wins, second pulse; mask change mid-pulse
    SRC = 4'b0000;
    tick();
    SRC = 4'b0001;
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t4_pend_setwins", rdv, 8'h01);
    chk("t4_idle_low", INT_OUT, 0);
    tick();
    chk("t4_second_pulse", INT_OUT, 1);
    io_wr(MASK_ID, 8'h00);
    chk("t4_mask_no_shorten", INT_OUT, 1);
    rd(INFO_ID, rdv);          chk("t4_info_curid", rdv, 8'h40);
    tick();
    chk("t4_pulse_end", INT_OUT, 0);
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t4_pend_clear", rdv, 8'h00);

    // Upper mask bits discarded; ACK ignored in IDLE and ASSERT
    SRC = 4'b0010;
    io_wr(MASK_ID, 8'hF0);
    count_hi(3, hi);           chk("t5_upper_mask", hi, 0);
    rd(PEND_ID, rdv);          chk("t5_pend", rdv, 8'h02);
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t5_ack_idle_ign", rdv, 8'h02);
    io_wr(MASK_ID, 8'h0F);
    tick();
    chk("t5_assert", INT_OUT, 1);
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t5_ack_assert_ign", rdv, 8'h02);
    chk("t5_still_high", INT_OUT, 1);
    tick();
    rd(INFO_ID, rdv);          chk("t5_info", rdv, 8'h41);
    io_wr(ACK_ID, 8'h00);
    rd(PEND_ID, rdv);          chk("t5_pend_clear", rdv, 8'h00);
    SRC = 4'b0000;
    tick();

    // Acknowledge timeout behaviour
    SRC = 4'b0100;
    tick(); tick(); tick(); tick();
`ifdef INT_CTRL_TIMEOUT_EN
    repeat (15) tick();
    rd(INFO_ID, rdv);          chk("t6_info_waiting", rdv, 8'h42);
    tick();
    rd(INFO_ID, rdv);          chk("t6_info_timeout", rdv, 8'h82);
    chk("t6_low_idle", INT_OUT, 0);
    tick();
    chk("t6_reassert", INT_OUT, 1);
    tick(); tick();
    io_wr(ACK_ID, 8'h00);
    rd(INFO_ID, rdv);          chk("t6_flag_sticky", rdv, 8'h82);
    rd(INFO_ID, rdv);          chk("t6_read_nondestr", rdv, 8'h82);
    io_wr(ACK_ID, 8'h00);
    rd(INFO_ID, rdv);          chk("t6_flag_clear", rdv, 8'h02);
`else
    count_hi(40, hi);          chk("t6_no_timeout", hi, 0);
    rd(INFO_ID, rdv);          chk("t6_info_waiting", rdv, 8'h42);
    io_wr(ACK_ID, 8'h00);
    rd(INFO_ID, rdv);          chk("t6_info_ack", rdv, 8'h02);
`endif
    SRC = 4'b0000;
    tick();

    // Asynchronous reset mid-pulse, then first edge after reset
    SRC = 4'b0001;
    tick(); tick();
    chk("t7_mid_pulse", INT_OUT, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t7_async_drop", INT_OUT, 0);
    rd(PEND_ID, rdv);          chk("t7_pend_rst", rdv, 8'h00);
    rd(INFO_ID, rdv);          chk("t7_info_rst", rdv, 8'h00);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    tick();
    rd(PEND_ID, rdv);          chk("t7_first_edge", rdv, 8'h01);
    count_hi(3, hi);           chk("t7_mask_rst", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, number of interrupt sources (legal 1..8).
REQ-002 Parameter PULSE_LEN, default 2, cycles INT_OUT is held high per request (legal 1..15).
REQ-003 Parameter TIMEOUT_CYC, default 1000, acknowledge timeout in cycles (used only under the macro).
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 SRC  input  NUM_SRC  synchronous interrupt request levels; a rising edge requests service.
REQ-007 PORT_ID  input  8  MCU port address.
REQ-008 OUT_PORT  input  8  MCU write data.
REQ-009 IO_STRB  input  1  MCU write strobe, qualifies PORT_ID/OUT_PORT.
REQ-010 RD_DATA  output  8  read data for the wrapper input mux, combinational from PORT_ID.
REQ-011 RD_HIT  output  1  high when PORT_ID equals PEND_ID or INFO_ID.
REQ-012 INT_OUT  output  1  interrupt to the MCU.

Function
REQ-013 Port IDs SHALL be MASK_ID=8'h60 (write), ACK_ID=8'h61 (write, data ignored), PEND_ID=8'h62 (read), INFO_ID=8'h63 (read).
REQ-014 A cycle with SRC[i]=1 and the previous-cycle SRC[i]=0 SHALL set pending[i] on that edge; levels held high SHALL NOT re-trigger.
REQ-015 IO_STRB with PORT_ID=MASK_ID SHALL load mask[NUM_SRC-1:0] from OUT_PORT; masking SHALL NOT clear pending bits.
REQ-016 FSM states: IDLE, ASSERT, WAIT_ACK.
REQ-017 IDLE->ASSERT when (pending & mask)!=0; on that edge the lowest set index of (pending & mask) SHALL be latched into cur_id and in_service set.
REQ-018 In ASSERT, INT_OUT SHALL be 1 for exactly PULSE_LEN cycles via a down-counter, then ASSERT->WAIT_ACK.
REQ-019 In WAIT_ACK, an ACK_ID write SHALL clear pending[cur_id] and in_service and return to IDLE; the next request may assert INT_OUT no earlier than the second cycle after the ACK.
REQ-020 ACK writes in IDLE or ASSERT SHALL be ignored.
REQ-021 A new SRC edge for cur_id in the same cycle as its ACK SHALL leave pending[cur_id]=1 (set wins).
REQ-022 Mask changes during ASSERT/WAIT_ACK SHALL NOT alter cur_id or shorten the pulse.
REQ-023 RD_DATA SHALL be {zero-fill, pending} at PEND_ID, {timeout_flag, in_service, 3'b0, cur_id[2:0]} at INFO_ID, 8'h00 otherwise.
REQ-024 Bits of MASK writes above NUM_SRC-1 SHALL be discarded.

Reset
REQ-025 RESET_N=0 SHALL immediately force pending=0, mask=0, cur_id=0, in_service=0, timeout_flag=0, counters=0, state=IDLE, INT_OUT=0, including mid-pulse.
REQ-026 The first SRC edge detection after reset SHALL treat the previous SRC sample as 0.

Configuration
REQ-027 With INT_CTRL_TIMEOUT_EN defined, WAIT_ACK SHALL return to IDLE after TIMEOUT_CYC cycles without ACK, set sticky timeout_flag, clear in_service, and keep pending[cur_id] set; a read of INFO_ID is non-destructive and an ACK write in IDLE SHALL clear timeout_flag.
REQ-028 Without INT_CTRL_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, and timeout_flag SHALL read 0 with no counter synthesized.

Structure
REQ-029 Package int_ctrl_pkg SHALL hold the FSM state enum and the four port-ID constants, which the wrapper also imports.
REQ-030 The lowest-index priority encoder SHALL be sub-module int_priority_enc (input vector, output index and valid).

Verification
REQ-031 Reset, mask=8'h0F, SRC[2] rises -> INT_OUT high exactly 2 cycles; INFO reads 8'h42; PEND reads 8'h04.
REQ-032 SRC[1] and SRC[3] rise in the same cycle -> cur_id=1 serviced first; after ACK, cur_id=3 is asserted; after the second ACK, PEND reads 8'h00.
REQ-033 Mask=8'h00, SRC[0] rises -> no INT_OUT and PEND=8'h01; then mask=8'h01 -> INT_OUT pulses within 2 cycles.
REQ-034 SRC[0] re-rises in the cycle its ACK is written -> pending[0] stays 1 and a second pulse follows.
REQ-035 RESET_N low during the ASSERT pulse -> INT_OUT drops to 0 asynchronously and all registers read 0.
REQ-036 With INT_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, no ACK -> IDLE after 16 cycles, INFO=8'h80 | cur_id, and the request re-asserts.
